// File: rtl/cvif_csb_req_adapter_pkg.sv
// Shared types and constants for the CVIF CSB request adapter.
package cvif_csb_pkg;

   localparam int ADDR_W   = 22;
   localparam int DATA_W   = 32;
   localparam int OFFSET_W = 12;

   // CVIF window 0x3000-0x3FFF in byte space: CSB word address bits [21:10]
   localparam logic [11:0] CVIF_BLOCK_BASE = 12'h003;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } csb_state_t;

   // CSB word address -> register block byte offset
   function automatic logic [OFFSET_W-1:0] csb_offset(input logic [ADDR_W-1:0] addr);
      return {addr[9:0], 2'b00};
   endfunction

endpackage

// File: rtl/cvif_csb_req_adapter_if.sv
// CSB request/response channels plus the CVIF register block bus.
// slave: the adapter; master: the CSB master and register block around it.
interface cvif_csb_req_adapter_if;

   logic                            req_pvld;
   logic                            req_prdy;
   logic [cvif_csb_pkg::ADDR_W-1:0] req_addr;
   logic [cvif_csb_pkg::DATA_W-1:0] req_wdat;
   logic                            req_write;
   logic                            req_nposted;

   logic                            resp_valid;
   logic                            resp_ready;
   logic                            resp_is_wr;
   logic                            resp_error;
   logic [cvif_csb_pkg::DATA_W-1:0] resp_rdat;

   logic [cvif_csb_pkg::OFFSET_W-1:0] reg_offset;
   logic                              reg_wr_en;
   logic [cvif_csb_pkg::DATA_W-1:0]   reg_wr_data;
   logic [cvif_csb_pkg::DATA_W-1:0]   reg_rd_data;

   modport slave (
      input  req_pvld, req_addr, req_wdat, req_write, req_nposted,
      input  resp_ready, reg_rd_data,
      output req_prdy, resp_valid, resp_is_wr, resp_error, resp_rdat,
      output reg_offset, reg_wr_en, reg_wr_data
   );

   modport master (
      output req_pvld, req_addr, req_wdat, req_write, req_nposted,
      output resp_ready, reg_rd_data,
      input  req_prdy, resp_valid, resp_is_wr, resp_error, resp_rdat,
      input  reg_offset, reg_wr_en, reg_wr_data
   );

endinterface

// File: rtl/cvif_csb_req_adapter.sv
// CVIF CSB request adapter: one CSB request in flight, drives the CVIF
// register block and returns read data / non-posted write acks.
// Optional macro CVIF_CSB_ERR_CNT_EN adds a saturating out-of-range counter
// on err_cnt; without it err_cnt is tied to zero.
module cvif_csb_req_adapter
   import cvif_csb_pkg::*;
#(
   parameter logic [11:0] BLOCK_BASE = CVIF_BLOCK_BASE,
   parameter int          ERR_CNT_W  = 8
) (
   input  logic                 nvdla_core_clk,
   input  logic                 nvdla_core_rstn,
   cvif_csb_req_adapter_if.slave bus,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   csb_state_t state, state_nxt;
   logic       accept;
   logic       wr_q, np_q, hit_q;

   // state register
   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) state <= IDLE;
      else                  state <= state_nxt;
   end

   // next state and handshake/strobe outputs; strobes are masked during
   // reset so an aborted ISSUE never reaches the register block
   always_comb begin
      state_nxt       = state;
      accept          = 1'b0;
      bus.req_prdy    = 1'b0;
      bus.resp_valid  = 1'b0;
      bus.reg_wr_en   = 1'b0;
      case (state)
         IDLE: begin
            bus.req_prdy = nvdla_core_rstn;
            if (bus.req_pvld) begin
               accept    = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            bus.reg_wr_en = wr_q & hit_q & nvdla_core_rstn;
            state_nxt     = (!wr_q || np_q) ? RESP : IDLE;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // request capture; offset and write data hold between requests
   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         bus.reg_offset  <= '0;
         bus.reg_wr_data <= '0;
         wr_q            <= 1'b0;
         np_q            <= 1'b0;
         hit_q           <= 1'b0;
      end else if (accept) begin
         bus.reg_offset  <= csb_offset(bus.req_addr);
         bus.reg_wr_data <= bus.req_wdat;
         wr_q            <= bus.req_write;
         np_q            <= bus.req_nposted;
         hit_q           <= (bus.req_addr[21:10] == BLOCK_BASE);
      end
   end

   // response fields latched at the end of ISSUE, stable through RESP
   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         bus.resp_is_wr <= 1'b0;
         bus.resp_error <= 1'b0;
         bus.resp_rdat  <= '0;
      end else if (state == ISSUE) begin
         bus.resp_is_wr <= wr_q;
         bus.resp_error <= !hit_q;
         bus.resp_rdat  <= (!wr_q && hit_q) ? bus.reg_rd_data : '0;
      end
   end

`ifdef CVIF_CSB_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q;

   // saturating count of out-of-range ISSUE cycles
   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn)
         err_cnt_q <= '0;
      else if (state == ISSUE && !hit_q && err_cnt_q != {ERR_CNT_W{1'b1}})
         err_cnt_q <= err_cnt_q + 1'b1;
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_cvif_csb_req_adapter.sv
// Self-checking bench for cvif_csb_req_adapter: directed vector table,
// hand-written multi-cycle sequences, and randomized traffic against a
// behavioural model (register array + error count).
module tb_cvif_csb_req_adapter;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] err_cnt;

   cvif_csb_req_adapter_if bus();

   cvif_csb_req_adapter dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rstn(rstn),
      .bus            (bus),
      .err_cnt        (err_cnt)
   );

   always #5 clk = ~clk;

   // register block stand-in: combinational read, write on strobe
   logic [31:0] mem [0:1023];
   logic        mem_init = 1'b0;
   int          wr_pulses = 0;
   int          resp_cycles = 0;

   assign bus.reg_rd_data = mem[bus.reg_offset[11:2]];

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A5_0000 | i;
         mem[5]   <= 32'h0000_0100;
         mem_init <= 1'b1;
      end else if (bus.reg_wr_en === 1'b1) begin
         mem[bus.reg_offset[11:2]] <= bus.reg_wr_data;
      end
      if (bus.reg_wr_en === 1'b1) wr_pulses <= wr_pulses + 1;
      if (bus.resp_valid === 1'b1) resp_cycles <= resp_cycles + 1;
   end

   // reference model state
   logic [31:0] ref_mem [0:1023];
   int          exp_err = 0;
   int          total = 0;
   int          bad = 0;

   function automatic logic [7:0] exp_cnt();
`ifdef CVIF_CSB_ERR_CNT_EN
      return (exp_err > 255) ? 8'hFF : exp_err[7:0];
`else
      return 8'h00;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".prdy"},   bus.req_prdy,    1);
      chk({tag, ".rvalid"}, bus.resp_valid,  0);
      chk({tag, ".is_wr"},  bus.resp_is_wr,  0);
      chk({tag, ".error"},  bus.resp_error,  0);
      chk({tag, ".rdat"},   bus.resp_rdat,   0);
      chk({tag, ".offset"}, bus.reg_offset,  0);
      chk({tag, ".wen"},    bus.reg_wr_en,   0);
      chk({tag, ".wdata"},  bus.reg_wr_data, 0);
      chk({tag, ".errcnt"}, err_cnt,         0);
   endtask

   // present a request and return at posedge+1 of the cycle after acceptance
   task automatic accept_req(input string tag, input logic [21:0] a, input logic [31:0] d,
                             input logic w, input logic np);
      int n = 0;
      @(posedge clk); #1;
      bus.req_addr = a; bus.req_wdat = d; bus.req_write = w; bus.req_nposted = np;
      bus.req_pvld = 1'b1;
      @(negedge clk);
      while (bus.req_prdy !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".accepted"}, (n < 20), 1);
      @(posedge clk); #1;
      bus.req_pvld = 1'b0;
   endtask

   // full transaction with expected values; ends at a negedge in IDLE
   task automatic run(input string tag, input logic [21:0] a, input logic [31:0] d,
                      input logic w, input logic np, input int hold, input logic junk_rdy,
                      input logic e_wen, input logic [11:0] e_off, input logic e_resp,
                      input logic e_err, input logic [31:0] e_rdat);
      bus.resp_ready = junk_rdy;
      accept_req(tag, a, d, w, np);
      if (e_err) exp_err++;
      if (w && !e_err) ref_mem[a[9:0]] = d;
      @(negedge clk);
      chk({tag, ".wen"},    bus.reg_wr_en,   e_wen);
      chk({tag, ".offset"}, bus.reg_offset,  e_off);
      chk({tag, ".wdata"},  bus.reg_wr_data, d);
      chk({tag, ".prdy_issue"}, bus.req_prdy, 0);
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      @(negedge clk);
      chk({tag, ".rvalid"}, bus.resp_valid, e_resp);
      if (e_resp) begin
         for (int i = 0; i < hold; i++) begin
            chk({tag, ".is_wr"}, bus.resp_is_wr, w);
            chk({tag, ".error"}, bus.resp_error, e_err);
            chk({tag, ".rdat"},  bus.resp_rdat,  e_rdat);
            chk({tag, ".prdy_resp"}, bus.req_prdy, 0);
            chk({tag, ".rvalid_hold"}, bus.resp_valid, 1);
            @(negedge clk);
         end
         chk({tag, ".is_wr"}, bus.resp_is_wr, w);
         chk({tag, ".error"}, bus.resp_error, e_err);
         chk({tag, ".rdat"},  bus.resp_rdat,  e_rdat);
         chk({tag, ".prdy_resp"}, bus.req_prdy, 0);
         bus.resp_ready = 1'b1;
         @(posedge clk); #1;
         bus.resp_ready = 1'b0;
         @(negedge clk);
         chk({tag, ".rvalid_done"}, bus.resp_valid, 0);
      end
      chk({tag, ".prdy_idle"}, bus.req_prdy, 1);
      chk({tag, ".errcnt"}, err_cnt, exp_cnt());
   endtask

   typedef struct {
      logic [21:0] addr;
      logic [31:0] wdat;
      logic        write;
      logic        np;
      int          hold;
      logic        e_wen;
      logic [11:0] e_off;
      logic        e_resp;
      logic        e_err;
      logic [31:0] e_rdat;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int p0, r0;
      bus.req_pvld = 0; bus.req_addr = '0; bus.req_wdat = '0;
      bus.req_write = 0; bus.req_nposted = 0; bus.resp_ready = 0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hA5A5_0000 | i;
      ref_mem[5] = 32'h0000_0100;

      //        addr        wdat          w  np hold wen off     resp err rdat
      vecs[0] = '{22'h000C01, 32'h0000_0403, 1, 1, 0, 1, 12'h004, 1, 0, 32'h0};
      vecs[1] = '{22'h000C05, 32'h0,         0, 0, 0, 0, 12'h014, 1, 0, 32'h0000_0100};
      vecs[2] = '{22'h001000, 32'h0,         0, 0, 0, 0, 12'h000, 1, 1, 32'h0};
      vecs[3] = '{22'h000C01, 32'h0,         0, 1, 0, 0, 12'h004, 1, 0, 32'h0000_0403};
      vecs[4] = '{22'h3FFFFF, 32'hDEAD_BEEF, 1, 1, 0, 0, 12'hFFC, 1, 1, 32'h0};
      vecs[5] = '{22'h000FFF, 32'h0,         0, 0, 0, 0, 12'hFFC, 1, 0, 32'hA5A5_03FF};
      vecs[6] = '{22'h000C07, 32'h0,         0, 0, 5, 0, 12'h01C, 1, 0, 32'hA5A5_0007};
      vecs[7] = '{22'h000C02, 32'h1234_5678, 1, 0, 0, 1, 12'h008, 0, 0, 32'h0};
      vecs[8] = '{22'h000C02, 32'h0,         0, 0, 2, 0, 12'h008, 1, 0, 32'h1234_5678};
      vecs[9] = '{22'h000BFF, 32'h0,         0, 0, 0, 0, 12'hFFC, 1, 1, 32'h0};

      // reset: ready low while reset is asserted, reset values after release
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.prdy_in_reset", bus.req_prdy, 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      chk_reset_vals("rst");

      // directed table
      for (int i = 0; i < 10; i++)
         run($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdat, vecs[i].write, vecs[i].np,
             vecs[i].hold, 1'b0, vecs[i].e_wen, vecs[i].e_off, vecs[i].e_resp,
             vecs[i].e_err, vecs[i].e_rdat);

      // back-to-back posted writes: one per two cycles, no responses
      p0 = wr_pulses; r0 = resp_cycles;
      @(posedge clk); #1;
      bus.req_addr = 22'h000C03; bus.req_wdat = 32'h3333_0003;
      bus.req_write = 1; bus.req_nposted = 0; bus.req_pvld = 1;
      @(negedge clk);
      chk("b2b.prdy0", bus.req_prdy, 1);
      @(posedge clk); #1;
      bus.req_addr = 22'h000C04; bus.req_wdat = 32'h4444_0004;
      @(negedge clk);
      chk("b2b.prdy1", bus.req_prdy, 0);
      chk("b2b.wen1", bus.reg_wr_en, 1);
      chk("b2b.off1", bus.reg_offset, 12'h00C);
      chk("b2b.wdata1", bus.reg_wr_data, 32'h3333_0003);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b.prdy2", bus.req_prdy, 1);
      chk("b2b.wen2", bus.reg_wr_en, 0);
      @(posedge clk); #1;
      bus.req_pvld = 0;
      @(negedge clk);
      chk("b2b.prdy3", bus.req_prdy, 0);
      chk("b2b.wen3", bus.reg_wr_en, 1);
      chk("b2b.off3", bus.reg_offset, 12'h010);
      chk("b2b.wdata3", bus.reg_wr_data, 32'h4444_0004);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b.pulses", wr_pulses - p0, 2);
      chk("b2b.no_resp", resp_cycles - r0, 0);
      ref_mem[3] = 32'h3333_0003;
      ref_mem[4] = 32'h4444_0004;

      // reset during ISSUE of a write: strobe suppressed, clean state after
      p0 = wr_pulses;
      accept_req("rst_issue", 22'h000C06, 32'hBAD0_0006, 1, 1);
      rstn = 1'b0;
      @(negedge clk);
      chk("rst_issue.wen", bus.reg_wr_en, 0);
      chk("rst_issue.prdy", bus.req_prdy, 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      exp_err = 0;
      @(negedge clk);
      chk_reset_vals("rst_issue");
      chk("rst_issue.pulses", wr_pulses - p0, 0);

      // reset during RESP: valid drops at the next edge
      accept_req("rst_resp", 22'h000C05, 32'h0, 0, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_resp.rvalid_before", bus.resp_valid, 1);
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      chk_reset_vals("rst_resp");

      // randomized traffic against the model
      for (int t = 0; t < 150; t++) begin
         logic [21:0] a;
         logic [31:0] d;
         logic        w, np, hit;
         a   = ($urandom_range(0, 3) != 0) ? {12'h003, 6'h00, 4'($urandom_range(0, 15))}
                                           : 22'($urandom);
         d   = $urandom;
         w   = 1'($urandom);
         np  = 1'($urandom);
         hit = (a[21:10] == 12'h003);
         run($sformatf("rnd%0d", t), a, d, w, np, $urandom_range(0, 3), 1'($urandom),
             w & hit, {a[9:0], 2'b00}, !w || np, !hit,
             (!w && hit) ? ref_mem[a[9:0]] : 32'h0);
      end

      // 300 posted out-of-range writes: silently dropped, counter saturates
      p0 = wr_pulses; r0 = resp_cycles;
      for (int i = 0; i < 300; i++)
         accept_req("sat", 22'h001000 | 22'(i), 32'hFFFF_0000 | i, 1, 0);
      exp_err += 300;
      @(posedge clk); #1;
      @(negedge clk);
      chk("sat.errcnt", err_cnt, exp_cnt());
      chk("sat.pulses", wr_pulses - p0, 0);
      chk("sat.no_resp", resp_cycles - r0, 0);
      chk("sat.prdy", bus.req_prdy, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
